pixel_line_fetch: RTL and testbench
===================================

Name: pixel_line_fetch

Overview:
Downstream consumer of the video timing generator. Prefetches one display line of 8-bit pixel codes from system memory into a ping-pong line buffer while the previous line is shown. Streams pixels out during the active region to the CLUT/mixer stage. One memory word holds two pixels.

Parameters:
LINE_PIXELS, 384, max active pixels per line (even; 360/384 standard)
ADDR_W, 22, memory word address width
WORDS, LINE_PIXELS/2, derived; 16-bit words fetched per line

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse at video_y==0, video_x==0
line_start  in  1  one-cycle pulse at video_x==0 of every line
pix_active  in  1  high for each active pixel cycle of the current line
fetch_en  in  1  enables memory fetching; sampled at frame_start/line_start
base_addr  in  ADDR_W  word address of line 0, latched at frame_start
line_stride  in  ADDR_W  words between consecutive line starts
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  word address, stable while mem_req=1
mem_ack  in  1  one-cycle ack; mem_data valid in same cycle
mem_data  in  16  [15:8] = even pixel, [7:0] = odd pixel
pixel  out  8  pixel code
pixel_valid  out  1  pixel qualifier
underrun  out  1  sticky; line shown before its fetch completed
underrun_clr  in  1  clears underrun

Behaviour:
- Reset: mem_req=0, mem_addr=0, pixel=0, pixel_valid=0, underrun=0. FSM=IDLE. fill_bank=0. display_bank=0. Both banks marked invalid.
- Fill FSM states: IDLE, FETCH, DRAIN.
- IDLE->FETCH on fetch start. Word counter = 0. mem_req=1, mem_addr = line_addr.
- FETCH: on mem_ack, write mem_data to fill_bank[word]. Advance word and mem_addr by 1. mem_req stays high.
- FETCH exit: ack of word WORDS-1 drops mem_req the next cycle, marks fill_bank valid, and returns to IDLE.
- Handshake: mem_addr and mem_req are never changed while a request is outstanding. Only mem_ack ends a request.
- frame_start: latch line_addr=base_addr. Invalidate both banks. fill_bank=0. Display goes blank.
  - Idle FSM with fetch_en=1: fetch line 0 into bank 0.
  - FETCH FSM: go to DRAIN. Keep mem_req until the next ack and discard that data. Then start the frame_start fetch. No extra address is issued.
- line_start (without frame_start), fill_bank valid:
  - display_bank <= fill_bank.
  - fill_bank flips and the new fill_bank is invalidated.
  - line_addr += line_stride (mod 2^ADDR_W).
  - If fetch_en=1, start the next fetch.
- line_start, fill_bank not valid, and (FSM busy or fetch_en was 1):
  - Set underrun.
  - Blank the display for this line.
  - No swap, no address advance. The fetch continues.
- line_start, fill_bank not valid, FSM idle, fetch_en=0: blank the line with no flag.
- frame_start and line_start in the same cycle: frame_start rules only.
- Output path:
  - Pixel index resets to 0 at line_start and increments on each pix_active cycle, saturating at LINE_PIXELS.
  - Buffer read is registered. pixel/pixel_valid appear 1 cycle after the pix_active cycle.
  - pixel = display_bank byte [idx] (even idx -> [15:8]).
  - pixel=0, pixel_valid=1 when idx >= LINE_PIXELS or the display is blank.
  - pixel_valid=0 when pix_active was 0.
- Buffer is dual-ported: simultaneous write to fill_bank and read from display_bank. The two banks are never the same during the active region.
- underrun_clr clears underrun. A set in the same cycle wins.
- Reset asserted mid-fetch: mem_req drops immediately (asynchronous). Memory side tolerates an abandoned request.

Test Plan:
- base_addr=0x1000, stride=0xC0, mem_ack every cycle, frame_start -> 192 requests at addresses 0x1000..0x10BF. mem_req low after the last ack.
- mem_data=0xAB12 at word 0, next line_start, 4 pix_active cycles -> pixel = 0xAB, 0x12, word1 hi, word1 lo. Each pixel is 1 cycle after its pix_active.
- Three line_starts with fetch complete -> second-line fetch starts at 0x10C0 and third at 0x1180. Banks alternate 0,1,0.
- mem_ack every 4th cycle, line_start 400 cycles after fetch start -> underrun=1 and line output is 0s. The fetch finishes, and the next line_start swaps normally with no address skip.
- frame_start while mem_req outstanding for 0x1050, ack 3 cycles later -> that data is discarded. Next request is base_addr with no intermediate address.
- 390 pix_active cycles with LINE_PIXELS=384 -> pixels 384..389 are 0 with pixel_valid=1. Async reset mid-line -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/pixel_line_fetch.sv
// pixel_line_fetch: prefetches one display line of 8-bit pixel codes from
// system memory into a ping-pong line buffer while the previous line is
// being shown, then streams the shown line out during the active region.
// Each 16-bit memory word carries two pixels, even pixel in the high byte.
module pixel_line_fetch #(
  parameter int LINE_PIXELS = 384,
  parameter int ADDR_W      = 22,
  parameter int WORDS       = LINE_PIXELS / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              pix_active,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] line_stride,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic [7:0]        pixel,
  output logic              pixel_valid,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int IDX_W  = $clog2(LINE_PIXELS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fill_state_e;

  fill_state_e        state_q, state_d;
  logic [WIDX_W-1:0]  word_q, word_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]  line_addr_q, line_addr_d;
  logic               fill_bank_q, fill_bank_d;
  logic               disp_bank_q, disp_bank_d;
  logic [1:0]         bank_valid_q, bank_valid_d;
  logic               blank_q, blank_d;
  logic               pend_q, pend_d;
  logic               underrun_q, underrun_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         pixel_q;
  logic               pixel_valid_q;

  logic               underrun_set;
  logic               wr_en;
  logic               start_fetch;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  next_line_addr;

  logic [IDX_W-1:0]   idx_eff;
  logic               idx_in_range;
  logic [WIDX_W-1:0]  rd_word;
  logic [15:0]        rd_data;

  logic [15:0]        linebuf [2][WORDS];

  assign next_line_addr = line_addr_q + line_stride;

  // Fill FSM next state, bank bookkeeping and frame/line event handling.
  // A request in flight is never altered; frame_start during a fetch parks
  // in DRAIN until the outstanding ack arrives and then restarts at base.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    line_addr_d  = line_addr_q;
    fill_bank_d  = fill_bank_q;
    disp_bank_d  = disp_bank_q;
    bank_valid_d = bank_valid_q;
    blank_d      = blank_q;
    pend_d       = pend_q;
    underrun_set = 1'b0;
    wr_en        = 1'b0;
    start_fetch  = 1'b0;
    start_addr   = line_addr_q;

    case (state_q)
      FETCH: begin
        if (mem_ack) begin
          wr_en = 1'b1;
          if (word_q == WIDX_W'(WORDS - 1)) begin
            mem_req_d                 = 1'b0;
            bank_valid_d[fill_bank_q] = 1'b1;
            state_d                   = IDLE;
          end else begin
            word_d     = word_q + WIDX_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (pend_q) begin
            start_fetch = 1'b1;
            start_addr  = line_addr_q;
          end
        end
      end
      default: begin
      end
    endcase

    if (frame_start) begin
      line_addr_d  = base_addr;
      bank_valid_d = 2'b00;
      fill_bank_d  = 1'b0;
      blank_d      = 1'b1;
      wr_en        = 1'b0;
      start_fetch  = 1'b0;
      if ((state_q == IDLE) || mem_ack) begin
        // Nothing left outstanding: begin the new frame right away.
        mem_req_d = 1'b0;
        state_d   = IDLE;
        pend_d    = 1'b0;
        if (fetch_en) begin
          start_fetch = 1'b1;
          start_addr  = base_addr;
        end
      end else begin
        state_d    = DRAIN;
        mem_req_d  = 1'b1;
        mem_addr_d = mem_addr_q;
        word_d     = word_q;
        pend_d     = fetch_en;
      end
    end else if (line_start) begin
      if (bank_valid_q[fill_bank_q]) begin
        disp_bank_d                = fill_bank_q;
        fill_bank_d                = ~fill_bank_q;
        bank_valid_d[~fill_bank_q] = 1'b0;
        blank_d                    = 1'b0;
        line_addr_d                = next_line_addr;
        if (fetch_en && (state_q == IDLE)) begin
          start_fetch = 1'b1;
          start_addr  = next_line_addr;
        end
      end else begin
        blank_d = 1'b1;
        if ((state_q != IDLE) || fetch_en) begin
          underrun_set = 1'b1;
        end
        if ((state_q == IDLE) && fetch_en) begin
          start_fetch = 1'b1;
          start_addr  = line_addr_q;
        end
      end
    end

    if (start_fetch) begin
      state_d    = FETCH;
      word_d     = '0;
      mem_req_d  = 1'b1;
      mem_addr_d = start_addr;
    end

    underrun_d = underrun_set | (underrun_q & ~underrun_clr);
  end

  // Pixel index for the current cycle restarts at line_start and saturates
  // at LINE_PIXELS so that overlong lines read as blank.
  always_comb begin
    idx_eff      = line_start ? '0 : idx_q;
    idx_in_range = (idx_eff < IDX_W'(LINE_PIXELS));
    idx_d        = (pix_active && idx_in_range) ? (idx_eff + IDX_W'(1)) : idx_eff;
    rd_word      = idx_in_range ? WIDX_W'(idx_eff >> 1) : '0;
    rd_data      = linebuf[disp_bank_d][rd_word];
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      word_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      line_addr_q  <= '0;
      fill_bank_q  <= 1'b0;
      disp_bank_q  <= 1'b0;
      bank_valid_q <= 2'b00;
      blank_q      <= 1'b1;
      pend_q       <= 1'b0;
      underrun_q   <= 1'b0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      line_addr_q  <= line_addr_d;
      fill_bank_q  <= fill_bank_d;
      disp_bank_q  <= disp_bank_d;
      bank_valid_q <= bank_valid_d;
      blank_q      <= blank_d;
      pend_q       <= pend_d;
      underrun_q   <= underrun_d;
      idx_q        <= idx_d;
    end
  end

  // Line buffer write port: fetched words land in the bank being filled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      linebuf[fill_bank_q][word_q] <= mem_data;
    end
  end

  // Registered pixel output: one cycle after each pix_active cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_q       <= 8'h00;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= pix_active;
      if (pix_active && idx_in_range && !blank_d) begin
        pixel_q <= idx_eff[0] ? rd_data[7:0] : rd_data[15:8];
      end else begin
        pixel_q <= 8'h00;
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pixel_line_fetch.sv
// Testbench for pixel_line_fetch: a memory responder with configurable ack
// spacing, a line-level behavioural model of the pixel stream, and a
// per-cycle compare process, plus directed scenario checks.
module tb_pixel_line_fetch;

  localparam int LP = 384;
  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start, line_start, pix_active, fetch_en;
  logic [AW-1:0] base_addr, line_stride;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_data;
  logic [7:0]    pixel;
  logic          pixel_valid;
  logic          underrun;
  logic          underrun_clr;

  int tests = 0;
  int fails = 0;

  int ackLatency = 1;
  bit ackHold = 1'b0;
  bit checkOn = 1'b0;

  logic [AW-1:0] reqLog[$];
  logic [7:0]    seenPix[$];

  bit            showBlank;
  logic [AW-1:0] showAddr;

  bit            mBlank;
  logic [AW-1:0] mAddr;
  int            mIdx;
  bit            effBlank;
  logic [AW-1:0] effAddr;
  int            effIdx;
  logic          expValid;
  logic [7:0]    expPix;
  bit            holdValid;
  logic [AW-1:0] holdAddr;

  pixel_line_fetch #(.LINE_PIXELS(LP), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_active  (pix_active),
    .fetch_en    (fetch_en),
    .base_addr   (base_addr),
    .line_stride (line_stride),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of the word address.
  function automatic logic [15:0] memWord(input logic [AW-1:0] a);
    if (a == 22'h1000) return 16'hAB12;
    return {a[7:0] ^ 8'hC3, a[15:8] + a[7:0]};
  endfunction

  // Expected pixel for index idx of a line whose words start at addr.
  function automatic logic [7:0] pixModel(input bit blank, input logic [AW-1:0] addr, input int idx);
    logic [15:0] w;
    if (blank || idx >= LP) return 8'h00;
    w = memWord(addr + AW'(idx / 2));
    return (idx % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory responder: acks every ackLatency cycles while a request is up.
  initial begin
    int waitCnt;
    waitCnt  = 0;
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !mem_req || ackHold) begin
        mem_ack = 1'b0;
        waitCnt = 0;
      end else if (waitCnt >= ackLatency - 1) begin
        mem_ack  = 1'b1;
        mem_data = memWord(mem_addr);
        waitCnt  = 0;
      end else begin
        mem_ack = 1'b0;
        waitCnt++;
      end
    end
  end

  // Line state seen by the model in the current cycle.
  always_comb begin
    effBlank = frame_start ? 1'b1 : (line_start ? showBlank : mBlank);
    effAddr  = (line_start && !frame_start) ? showAddr : mAddr;
    effIdx   = line_start ? 0 : mIdx;
  end

  // Behavioural model: what the pixel stream must be, plus request log.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mBlank    <= 1'b1;
      mAddr     <= '0;
      mIdx      <= 0;
      expValid  <= 1'b0;
      expPix    <= 8'h00;
      holdValid <= 1'b0;
      holdAddr  <= '0;
    end else begin
      mBlank    <= effBlank;
      mAddr     <= effAddr;
      mIdx      <= (pix_active && effIdx < LP) ? effIdx + 1 : effIdx;
      expValid  <= pix_active;
      expPix    <= pix_active ? pixModel(effBlank, effAddr, effIdx) : 8'h00;
      holdValid <= mem_req && !mem_ack;
      holdAddr  <= mem_addr;
      if (mem_req && mem_ack) reqLog.push_back(mem_addr);
    end
  end

  // Per-cycle comparison of outputs against the model.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("pixel_valid", {31'd0, pixel_valid}, {31'd0, expValid});
      checkOutput("pixel", {24'd0, pixel}, {24'd0, expPix});
      if (holdValid) begin
        checkOutput("req_held", {31'd0, mem_req}, 32'd1);
        checkOutput("addr_held", {10'd0, mem_addr}, {10'd0, holdAddr});
      end
      if (pixel_valid) seenPix.push_back(pixel);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit fs, input bit ls, input bit pa, input bit clr);
    frame_start  = fs;
    line_start   = ls;
    pix_active   = pa;
    underrun_clr = clr;
    tick();
  endtask

  task automatic runLine(input bit fs, input bit blank, input logic [AW-1:0] addr,
                         input int nPix, input int len, input bit clr);
    showBlank = blank;
    showAddr  = addr;
    seenPix.delete();
    applyStimulus(fs, 1'b1, 1'b0, clr);
    for (int i = 1; i < len; i++) applyStimulus(1'b0, 1'b0, (i <= nPix), 1'b0);
  endtask

  task automatic waitReqLow(input int maxCycles);
    int n;
    n = 0;
    while (mem_req && n < maxCycles) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("fetch_done", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    int n;
    reset        = 1'b1;
    frame_start  = 1'b0;
    line_start   = 1'b0;
    pix_active   = 1'b0;
    underrun_clr = 1'b0;
    fetch_en     = 1'b1;
    base_addr    = 22'h1000;
    line_stride  = 22'h0C0;
    showBlank    = 1'b1;
    showAddr     = '0;
    repeat (3) tick();
    checkOn = 1'b1;
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_addr", {10'd0, mem_addr}, 32'd0);
    checkOutput("rst_pixel", {24'd0, pixel}, 32'd0);
    checkOutput("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    checkOutput("rst_underrun", {31'd0, underrun}, 32'd0);
    reset = 1'b0;
    tick();

    // Frame 1, line 0: blank display while line 0 is fetched.
    $display("[TB] first frame, ack every cycle");
    reqLog.delete();
    runLine(1'b1, 1'b1, '0, 4, 250, 1'b0);
    checkOutput("req_count", reqLog.size(), 32'd192);
    checkOutput("req_first", {10'd0, reqLog[0]}, 32'h1000);
    checkOutput("req_last", {10'd0, reqLog[191]}, 32'h10BF);
    bad = 0;
    for (int i = 0; i < reqLog.size(); i++) if (reqLog[i] !== 22'h1000 + AW'(i)) bad++;
    checkOutput("req_seq", bad, 32'd0);
    checkOutput("req_low_after_last", {31'd0, mem_req}, 32'd0);

    // Line 1 shows line 0 data; line 2 fetch starts one stride on.
    reqLog.delete();
    runLine(1'b0, 1'b0, 22'h1000, 4, 250, 1'b0);
    checkOutput("pix_count", seenPix.size(), 32'd4);
    checkOutput("pix0", {24'd0, seenPix[0]}, 32'hAB);
    checkOutput("pix1", {24'd0, seenPix[1]}, 32'h12);
    checkOutput("pix2", {24'd0, seenPix[2]}, 32'hC2);
    checkOutput("pix3", {24'd0, seenPix[3]}, 32'h11);
    checkOutput("line2_addr", {10'd0, reqLog[0]}, 32'h10C0);
    checkOutput("line2_count", reqLog.size(), 32'd192);

    reqLog.delete();
    runLine(1'b0, 1'b0, 22'h10C0, 8, 250, 1'b0);
    checkOutput("line3_addr", {10'd0, reqLog[0]}, 32'h1180);
    reqLog.delete();
    runLine(1'b0, 1'b0, 22'h1180, 8, 250, 1'b0);
    checkOutput("line4_addr", {10'd0, reqLog[0]}, 32'h1240);

    // Slow memory: line_start arrives 400 cycles into a 768-cycle fetch.
    $display("[TB] underrun with ack every 4th cycle");
    ackLatency = 4;
    reqLog.delete();
    runLine(1'b1, 1'b1, '0, 4, 400, 1'b0);
    checkOutput("no_underrun_yet", {31'd0, underrun}, 32'd0);
    runLine(1'b0, 1'b1, '0, 4, 450, 1'b1);
    checkOutput("underrun_set_wins", {31'd0, underrun}, 32'd1);
    checkOutput("slow_count", reqLog.size(), 32'd192);
    checkOutput("slow_last", {10'd0, reqLog[191]}, 32'h10BF);
    reqLog.delete();
    runLine(1'b0, 1'b0, 22'h1000, 8, 250, 1'b0);
    checkOutput("no_addr_skip", {10'd0, reqLog[0]}, 32'h10C0);
    checkOutput("underrun_sticky", {31'd0, underrun}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("underrun_cleared", {31'd0, underrun}, 32'd0);
    waitReqLow(1000);

    // frame_start while the request for 0x1050 is outstanding.
    $display("[TB] frame_start during fetch");
    reqLog.delete();
    showBlank = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(mem_req && mem_addr == 22'h1050 && !mem_ack) && n < 2000) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("reach_1050", {10'd0, mem_addr}, 32'h1050);
    ackHold   = 1'b1;
    base_addr = 22'h2000;
    reqLog.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("drain_req", {31'd0, mem_req}, 32'd1);
    checkOutput("drain_addr", {10'd0, mem_addr}, 32'h1050);
    ackLatency = 1;
    ackHold    = 1'b0;
    waitReqLow(400);
    checkOutput("drain_count", reqLog.size(), 32'd193);
    checkOutput("drain_discard", {10'd0, reqLog[0]}, 32'h1050);
    checkOutput("restart_base", {10'd0, reqLog[1]}, 32'h2000);
    checkOutput("restart_last", {10'd0, reqLog[192]}, 32'h20BF);

    // Overlong line: pixels past LINE_PIXELS read as 0 but stay valid.
    $display("[TB] 390 active pixels");
    runLine(1'b0, 1'b0, 22'h2000, 390, 450, 1'b0);
    checkOutput("long_count", seenPix.size(), 32'd390);
    checkOutput("long_pix0", {24'd0, seenPix[0]}, 32'hC3);
    checkOutput("long_pix382", {24'd0, seenPix[382]}, 32'h7C);
    checkOutput("long_pix383", {24'd0, seenPix[383]}, 32'hDF);
    bad = 0;
    for (int i = 384; i < 390; i++) if (seenPix[i] !== 8'h00) bad++;
    checkOutput("long_tail_zero", bad, 32'd0);

    // Asynchronous reset in the middle of a line with a fetch running.
    $display("[TB] async reset mid-line");
    showBlank = 1'b0;
    showAddr  = 22'h20C0;
    seenPix.delete();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("req_before_reset", {31'd0, mem_req}, 32'd1);
    checkOutput("valid_before_reset", {31'd0, pixel_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("areset_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("areset_mem_addr", {10'd0, mem_addr}, 32'd0);
    checkOutput("areset_pixel", {24'd0, pixel}, 32'd0);
    checkOutput("areset_pixel_valid", {31'd0, pixel_valid}, 32'd0);
    checkOutput("areset_underrun", {31'd0, underrun}, 32'd0);
    pix_active = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();

    checkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
